aer_class_decoder: RTL and testbench
====================================

// Module: aer_class_decoder
// PURPOSE
//  Receiving end of the AER output link of the SNN core; the decoder paired with the pixel encoder.
//  - Acknowledges every output spike with a 4-phase handshake.
//  - Counts spikes per output (class) neuron; declares the first class to reach SPIKE_THRESHOLD the winner.
//  - Pulses INFERENCE_DONE, which releases the encoder for the next image. A timeout picks the max-count class.
// PARAMETERS
//  N_CLASSES        10      number of class neurons
//  ADDR_BITS        8       AER address width
//  CLASS_BASE       0       AER address of class 0; class k at CLASS_BASE+k
//  SPIKE_THRESHOLD  4       spikes a class needs to win (>=1)
//  TIMEOUT_CYCLES   100000  CLK cycles in RUN before forced decision (>=1)
// PORTS
//  CLK               in   1                     clock
//  RST               in   1                     synchronous reset, active-high
//  START             in   1                     1-cycle pulse: new image sent, begin inference
//  AEROUT_ADDR       in   ADDR_BITS             spike address, stable while AEROUT_REQ high
//  AEROUT_REQ        in   1                     request, asynchronous to CLK
//  AEROUT_ACK        out  1                     acknowledge, registered
//  INFERENCE_DONE    out  1                     1-cycle pulse: decision made
//  INFERRED_CLASS    out  $clog2(N_CLASSES)     winning class, held until next decision
//  INFERENCE_TIMEOUT out  1                     1 if last decision came from timeout, held
// BEHAVIOUR
//  Reset: AEROUT_ACK=0, INFERENCE_DONE=0, INFERRED_CLASS=0, INFERENCE_TIMEOUT=0.
//  Reset also clears all counters, FSM=IDLE, handshake=WAIT_LOW. Reset mid-handshake drops ACK on the next edge.
//  Synchronizer: AEROUT_REQ passes through 2 flops -> req_s. Address is sampled only when req_s=1.
//  Handshake FSM, independent of the inference FSM:
//   WAIT_LOW -> WAIT_REQ when req_s=0. This prevents re-acking an event that was pending across reset.
//   WAIT_REQ, req_s=1: latch AEROUT_ADDR, ACK<=1, evt_valid<=1 for 1 cycle -> WAIT_REL.
//   WAIT_REL, req_s=0: ACK<=0 -> WAIT_REQ.
//   ACK therefore rises on the 3rd rising edge after REQ rises.
//  Every event is acknowledged in every inference state. The link never stalls.
//  Event decode:
//   In RUN with CLASS_BASE <= addr < CLASS_BASE+N_CLASSES: cnt[addr-CLASS_BASE]++.
//   Counters saturate at SPIKE_THRESHOLD, width $clog2(SPIKE_THRESHOLD+1).
//   Out-of-range address, or any event outside RUN: acknowledged, then discarded.
//   Address arithmetic is done in ADDR_BITS+1 bits to avoid wrap.
//  Inference FSM:
//   IDLE, START=1: clear all cnt and the timeout counter -> RUN.
//   RUN, event raises cnt[k] to SPIKE_THRESHOLD: winner=k, to_flag=0 -> DONE.
//    The count update happens the edge after evt_valid.
//   RUN, timer reaches TIMEOUT_CYCLES-1 with no winner -> DONE.
//    winner = index of the max cnt, lowest index on tie (all zero -> 0). to_flag=1.
//   RUN, START=1: restart. Clear counters and timer, stay in RUN.
//    START has priority over a same-cycle threshold hit.
//   DONE: INFERENCE_DONE=1 for exactly 1 cycle. INFERRED_CLASS and INFERENCE_TIMEOUT updated on that edge.
//    Then -> IDLE. START in DONE is ignored.
//  Latency: INFERENCE_DONE rises 2 edges after the ACK rise of the winning spike.
//  Only one event is in flight at a time, so no threshold ties occur.
// TESTING
//  T1 reset then idle:
//   all outputs 0; REQ held high through reset -> ACK stays 0 until REQ drops and rises again.
//  T2 handshake timing:
//   REQ rise -> ACK=1 on 3rd edge.
//   REQ fall -> ACK=0 within 3 edges.
//   Sender with 100 ns delays completes 20 events with no lost or duplicate acks.
//  T3 threshold win:
//   START, then addrs 3,7,3,3,7,3 (threshold 4).
//   -> INFERENCE_DONE 1-cycle pulse 2 edges after the 6th ACK rise; INFERRED_CLASS=3, INFERENCE_TIMEOUT=0.
//  T4 timeout:
//   TIMEOUT_CYCLES=1000, START, addrs 5,2,5,2 then silence.
//   -> DONE at cycle 1000 after START; class=2 (tie, lower index wins), INFERENCE_TIMEOUT=1.
//  T5 filtering:
//   addrs 200 and CLASS_BASE+N_CLASSES, plus events in IDLE -> all acked, counts unchanged, no DONE.
//  T6 restart:
//   START mid-RUN after class 4 has 3 spikes, then 4 spikes on class 1 -> INFERRED_CLASS=1.
//   A second START in the same cycle as the threshold hit -> no DONE.

Source files
------------

// File: rtl/aer_class_decoder.sv
// Receiving end of the SNN core's AER output link. Every spike is acknowledged with a
// 4-phase handshake and counted per class. The first class to reach threshold, or the leader on timeout, is reported.
module aer_class_decoder #(
    parameter int N_CLASSES       = 10,
    parameter int ADDR_BITS       = 8,
    parameter int CLASS_BASE      = 0,
    parameter int SPIKE_THRESHOLD = 4,
    parameter int TIMEOUT_CYCLES  = 100000,
    localparam int CLS_W = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [ADDR_BITS-1:0] AEROUT_ADDR,
    input  logic                 AEROUT_REQ,
    output logic                 AEROUT_ACK,
    output logic                 INFERENCE_DONE,
    output logic [CLS_W-1:0]     INFERRED_CLASS,
    output logic                 INFERENCE_TIMEOUT
);

    localparam int CNT_W = $clog2(SPIKE_THRESHOLD + 1);
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SPIKE_THRESHOLD - 1);
    localparam logic [CNT_W-1:0]   CNT_SAT  = CNT_W'(SPIKE_THRESHOLD);
    localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_BITS:0] ADDR_LO  = (ADDR_BITS + 1)'(CLASS_BASE);
    localparam logic [ADDR_BITS:0] ADDR_HI  = (ADDR_BITS + 1)'(CLASS_BASE + N_CLASSES);

    localparam logic [1:0] HS_WAIT_LOW = 2'd0;
    localparam logic [1:0] HS_WAIT_REQ = 2'd1;
    localparam logic [1:0] HS_WAIT_REL = 2'd2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic                 req_meta_r;
    logic                 req_sync_r;
    logic [1:0]           hs_state_r;
    logic                 ack_r;
    logic                 evt_valid_r;
    logic [ADDR_BITS-1:0] evt_addr_r;

    logic [1:0]           inf_state_r;
    logic [CNT_W-1:0]     cnt_r [N_CLASSES];
    logic [TMR_W-1:0]     timer_r;
    logic [CLS_W-1:0]     winner_r;
    logic                 to_flag_r;
    logic                 done_r;
    logic [CLS_W-1:0]     class_r;
    logic                 timeout_r;

    logic [ADDR_BITS:0]   evt_addr_ext_s;
    logic                 in_range_s;
    logic [CLS_W-1:0]     cls_idx_s;
    logic [CNT_W-1:0]     cur_cnt_s;
    logic                 hit_s;
    logic [CLS_W-1:0]     max_idx_s;
    logic [CNT_W-1:0]     max_cnt_s;

    // REQ synchronizer; deliberately not reset so a request held through reset stays visible
    always_ff @(posedge CLK) begin
        req_meta_r <= AEROUT_REQ;
        req_sync_r <= req_meta_r;
    end

    // 4-phase handshake; WAIT_LOW refuses to ack a request that was already pending at reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            hs_state_r  <= HS_WAIT_LOW;
            ack_r       <= 1'b0;
            evt_valid_r <= 1'b0;
            evt_addr_r  <= ADDR_BITS'(0);
        end else begin
            evt_valid_r <= 1'b0;
            case (hs_state_r)
                HS_WAIT_LOW: begin
                    if (!req_sync_r) hs_state_r <= HS_WAIT_REQ;
                end
                HS_WAIT_REQ: begin
                    if (req_sync_r) begin
                        evt_addr_r  <= AEROUT_ADDR;
                        ack_r       <= 1'b1;
                        evt_valid_r <= 1'b1;
                        hs_state_r  <= HS_WAIT_REL;
                    end
                end
                HS_WAIT_REL: begin
                    if (!req_sync_r) begin
                        ack_r      <= 1'b0;
                        hs_state_r <= HS_WAIT_REQ;
                    end
                end
                default: begin
                    ack_r      <= 1'b0;
                    hs_state_r <= HS_WAIT_LOW;
                end
            endcase
        end
    end

    // Event decode; the extra address bit keeps CLASS_BASE+N_CLASSES from wrapping
    always_comb begin
        evt_addr_ext_s = {1'b0, evt_addr_r};
        in_range_s     = (evt_addr_ext_s >= ADDR_LO) && (evt_addr_ext_s < ADDR_HI);
        cls_idx_s      = CLS_W'(evt_addr_ext_s - ADDR_LO);
        if (in_range_s) begin
            cur_cnt_s = cnt_r[cls_idx_s];
        end else begin
            cur_cnt_s = CNT_W'(0);
        end
        hit_s = evt_valid_r && in_range_s && (cur_cnt_s == CNT_LAST);
    end

    // Timeout decision: highest count, strict compare keeps the lowest index on ties
    always_comb begin
        max_idx_s = CLS_W'(0);
        max_cnt_s = CNT_W'(0);
        for (int k = 0; k < N_CLASSES; k++) begin
            if (cnt_r[k] > max_cnt_s) begin
                max_cnt_s = cnt_r[k];
                max_idx_s = CLS_W'(k);
            end else begin
                max_cnt_s = max_cnt_s;
            end
        end
    end

    // Inference FSM: START restarts and outranks a same-cycle threshold hit
    always_ff @(posedge CLK) begin
        if (RST) begin
            inf_state_r <= ST_IDLE;
            for (int k = 0; k < N_CLASSES; k++) cnt_r[k] <= CNT_W'(0);
            timer_r     <= TMR_W'(0);
            winner_r    <= CLS_W'(0);
            to_flag_r   <= 1'b0;
            done_r      <= 1'b0;
            class_r     <= CLS_W'(0);
            timeout_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (inf_state_r)
                ST_IDLE: begin
                    if (START) begin
                        for (int k = 0; k < N_CLASSES; k++) cnt_r[k] <= CNT_W'(0);
                        timer_r     <= TMR_W'(0);
                        inf_state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (START) begin
                        for (int k = 0; k < N_CLASSES; k++) cnt_r[k] <= CNT_W'(0);
                        timer_r <= TMR_W'(0);
                    end else if (hit_s) begin
                        cnt_r[cls_idx_s] <= CNT_SAT;
                        winner_r         <= cls_idx_s;
                        to_flag_r        <= 1'b0;
                        inf_state_r      <= ST_DONE;
                    end else begin
                        timer_r <= timer_r + TMR_W'(1);
                        if (evt_valid_r && in_range_s && (cur_cnt_s != CNT_SAT)) begin
                            cnt_r[cls_idx_s] <= cur_cnt_s + CNT_W'(1);
                        end
                        if (timer_r == TMR_LAST) begin
                            winner_r    <= max_idx_s;
                            to_flag_r   <= 1'b1;
                            inf_state_r <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    done_r      <= 1'b1;
                    class_r     <= winner_r;
                    timeout_r   <= to_flag_r;
                    inf_state_r <= ST_IDLE;
                end
                default: begin
                    inf_state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign AEROUT_ACK        = ack_r;
    assign INFERENCE_DONE    = done_r;
    assign INFERRED_CLASS    = class_r;
    assign INFERENCE_TIMEOUT = timeout_r;

endmodule

// File: tb/tb_aer_class_decoder.sv
// Randomised self-checking bench for aer_class_decoder against a per-class spike-count model.
module tb_aer_class_decoder;

    localparam int NC   = 10;
    localparam int BASE = 0;
    localparam int TH   = 4;
    localparam int TO   = 1000;

    logic       CLK = 1'b0;
    logic       RST;
    logic       START;
    logic [7:0] AEROUT_ADDR;
    logic       AEROUT_REQ;
    logic       AEROUT_ACK;
    logic       INFERENCE_DONE;
    logic [3:0] INFERRED_CLASS;
    logic       INFERENCE_TIMEOUT;

    aer_class_decoder #(
        .N_CLASSES(NC), .ADDR_BITS(8), .CLASS_BASE(BASE),
        .SPIKE_THRESHOLD(TH), .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START),
        .AEROUT_ADDR(AEROUT_ADDR), .AEROUT_REQ(AEROUT_REQ), .AEROUT_ACK(AEROUT_ACK),
        .INFERENCE_DONE(INFERENCE_DONE), .INFERRED_CLASS(INFERRED_CLASS),
        .INFERENCE_TIMEOUT(INFERENCE_TIMEOUT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0, done_hi = 0, last_done = -1, ack_rises = 0;
    logic ack_q = 1'b0;
    int n_checks = 0, n_pass = 0;

    // Reference model: spike count per class and whether an inference is running
    int cnt_m [NC];
    bit run_m = 1'b0;

    // Cycle counter plus DONE / ACK activity, sampled 1 ns after each edge
    always @(posedge CLK) begin
        #1;
        cyc++;
        if (INFERENCE_DONE) begin
            done_hi++;
            last_done = cyc;
        end
        if (AEROUT_ACK && !ack_q) ack_rises++;
        ack_q = AEROUT_ACK;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    function automatic int model_argmax();
        int best = 0;
        for (int k = 1; k < NC; k++) if (cnt_m[k] > cnt_m[best]) best = k;
        return best;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NC; k++) cnt_m[k] = 0;
    endtask

    task automatic pulse_start(output int s_cyc);
        START = 1'b1;
        tick(1);
        s_cyc = cyc;
        START = 1'b0;
        model_clear();
        run_m = 1'b1;
    endtask

    // One full 4-phase transfer; optionally raises START so it lands on the count-update edge
    task automatic send(input logic [7:0] a, input bit start_at_hit,
                        output int ack_cyc, output int rise_n, output int fall_n);
        bit fallen = 1'b0;
        AEROUT_ADDR = a;
        AEROUT_REQ  = 1'b1;
        ack_cyc = -1;
        rise_n  = 0;
        fall_n  = 0;
        for (int i = 0; i < 20 && ack_cyc < 0; i++) begin
            tick(1);
            rise_n++;
            if (AEROUT_ACK) ack_cyc = cyc;
        end
        if (ack_cyc < 0) check("ack_rise_timeout", 0, 1);
        if (start_at_hit) START = 1'b1;
        AEROUT_REQ = 1'b0;
        for (int i = 0; i < 20 && !fallen; i++) begin
            tick(1);
            fall_n++;
            if (fall_n == 1) START = 1'b0;
            if (!AEROUT_ACK) fallen = 1'b1;
        end
        if (!fallen) check("ack_fall_timeout", 0, 1);
        tick($urandom_range(0, 2));
    endtask

    task automatic ev(input int a, input bit sa);
        int d0, ac, rn, fn;
        bit win = 1'b0;
        int wcls = 0;
        d0 = done_hi;
        send(8'(a), sa, ac, rn, fn);
        if (sa) begin
            model_clear();
            run_m = 1'b1;
        end else if (run_m && a >= BASE && a < BASE + NC) begin
            if (cnt_m[a - BASE] < TH) cnt_m[a - BASE]++;
            if (cnt_m[a - BASE] == TH) begin
                win   = 1'b1;
                wcls  = a - BASE;
                run_m = 1'b0;
            end
        end
        if (win) begin
            check("done_pulses", done_hi - d0, 1);
            check("done_latency", last_done - ac, 2);
            check("class", INFERRED_CLASS, wcls);
            check("timeout_flag", INFERENCE_TIMEOUT, 0);
        end else begin
            check("no_done", done_hi - d0, 0);
        end
    endtask

    // Decision one edge after the timer expiry edge, TO edges after START was sampled
    task automatic expect_timeout(input int s_cyc, input int d0);
        int exp_cls;
        exp_cls = model_argmax();
        while (cyc < s_cyc + TO + 3) tick(1);
        run_m = 1'b0;
        check("to_pulses", done_hi - d0, 1);
        check("to_when", last_done - s_cyc, TO + 1);
        check("to_class", INFERRED_CLASS, exp_cls);
        check("to_flag", INFERENCE_TIMEOUT, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, d0, ac, rn, fn, r0;
        bit ok;
        int seq3 [6] = '{3, 7, 3, 3, 7, 3};

        RST = 1'b1; START = 1'b0; AEROUT_REQ = 1'b1; AEROUT_ADDR = 8'd3;
        model_clear();
        tick(4);
        check("rst_ack", AEROUT_ACK, 0);
        check("rst_done", INFERENCE_DONE, 0);
        check("rst_class", INFERRED_CLASS, 0);
        check("rst_timeout", INFERENCE_TIMEOUT, 0);
        RST = 1'b0;
        tick(6);
        check("ack_req_held_through_reset", AEROUT_ACK, 0);
        AEROUT_REQ = 1'b0;
        tick(4);
        check("ack_after_release", AEROUT_ACK, 0);

        send(8'd3, 1'b0, ac, rn, fn);
        check("ack_rise_edges", rn, 3);
        check("ack_fall_edges", fn, 3);

        // Reset during a handshake drops ACK and blocks the pending request
        AEROUT_REQ = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick(1);
            ok = AEROUT_ACK;
        end
        check("ack_before_mid_reset", ok, 1);
        RST = 1'b1;
        tick(1);
        check("ack_mid_reset", AEROUT_ACK, 0);
        RST = 1'b0;
        tick(5);
        check("ack_pending_after_reset", AEROUT_ACK, 0);
        AEROUT_REQ = 1'b0;
        tick(4);

        // Loosely timed sender, 100 ns between phases
        r0 = ack_rises;
        d0 = done_hi;
        for (int e = 0; e < 20; e++) begin
            AEROUT_ADDR = 8'($urandom_range(0, 255));
            #100 AEROUT_REQ = 1'b1;
            for (int i = 0; i < 40 && !AEROUT_ACK; i++) #7;
            if (!AEROUT_ACK) check("slow_ack_rise", 0, 1);
            #100 AEROUT_REQ = 1'b0;
            for (int i = 0; i < 40 && AEROUT_ACK; i++) #7;
            if (AEROUT_ACK) check("slow_ack_fall", 1, 0);
        end
        tick(2);
        check("slow_ack_count", ack_rises - r0, 20);
        check("slow_no_done", done_hi - d0, 0);

        for (int i = 0; i < 4; i++) ev(6, 1'b0);

        pulse_start(s);
        foreach (seq3[i]) ev(seq3[i], 1'b0);

        pulse_start(s);
        ev(200, 1'b0);
        ev(BASE + NC, 1'b0);
        for (int i = 0; i < 3; i++) ev(6, 1'b0);
        ev(255, 1'b0);
        ev(6, 1'b0);

        pulse_start(s);
        for (int i = 0; i < 3; i++) ev(4, 1'b0);
        pulse_start(s);
        ev(4, 1'b0);
        for (int i = 0; i < 4; i++) ev(1, 1'b0);

        pulse_start(s);
        for (int i = 0; i < 3; i++) ev(2, 1'b0);
        ev(2, 1'b1);
        for (int i = 0; i < 4; i++) ev(2, 1'b0);

        d0 = done_hi;
        pulse_start(s);
        ev(5, 1'b0); ev(2, 1'b0); ev(5, 1'b0); ev(2, 1'b0);
        expect_timeout(s, d0);

        d0 = done_hi;
        pulse_start(s);
        for (int i = 0; i < 3; i++) ev($urandom_range(0, NC - 1), 1'b0);
        expect_timeout(s, d0);

        for (int round = 0; round < 8; round++) begin
            pulse_start(s);
            for (int g = 0; g < 60 && run_m; g++) begin
                if ($urandom_range(0, 7) == 0) ev($urandom_range(BASE + NC, 255), 1'b0);
                else ev($urandom_range(BASE, BASE + NC - 1), 1'b0);
            end
            if (run_m) check("round_no_winner", 0, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
